// File: rtl/key_event_decoder.sv
// Key gesture decoder: turns a debounced key level into short/double/long/repeat pulses.
// Latency: each pulse is registered and appears the cycle after the deciding edge; no backpressure, pulses are fire-and-forget.
module key_event_decoder #(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DCLICK_CYC = 12_500_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_state,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic auto_repeat
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRESS1 = 3'd1;
    localparam logic [2:0] WAIT2  = 3'd2;
    localparam logic [2:0] PRESS2 = 3'd3;
    localparam logic [2:0] LONG   = 3'd4;

    // Terminal counts; each state compares against these before incrementing so cnt never wraps.
    localparam logic [25:0] LONG_LAST   = 26'(LONG_CYC - 1);
    localparam logic [25:0] DCLICK_LAST = 26'(DCLICK_CYC - 1);
    localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_CYC - 1);

    logic [2:0]  state;
    logic [25:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            auto_repeat  <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            auto_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_state) begin
                        state <= PRESS1;
                        cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (!key_state) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= LONG;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 26'd1;
                    end
                end
                WAIT2: begin
                    // A second press wins even on the final window cycle.
                    if (key_state) begin
                        state <= PRESS2;
                    end else if (cnt == DCLICK_LAST) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 26'd1;
                    end
                end
                PRESS2: begin
                    if (!key_state) begin
                        double_click <= 1'b1;
                        state        <= IDLE;
                    end
                end
                LONG: begin
                    if (!key_state) begin
                        state <= IDLE;
                    end else if (cnt == REPEAT_LAST) begin
                        auto_repeat <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 26'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timing parameters.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic reset;
    logic key_state;
    logic short_press, double_click, long_press, auto_repeat;

    always #5 clk = ~clk;

    key_event_decoder #(
        .LONG_CYC   (20),
        .DCLICK_CYC (10),
        .REPEAT_CYC (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_state    (key_state),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .auto_repeat  (auto_repeat)
    );

    typedef struct {
        int h1;
        int l1;
        int h2;
        int tail;
        int exp_short;
        int exp_dbl;
        int exp_long;
        int exp_rep;
        int exp_first;
    } vec_t;

    vec_t vecs[12];

    int checks = 0;
    int passed = 0;
    int mon_viol = 0;
    logic [3:0] prev_out = 4'b0;
    logic [3:0] outs;
    int n_short, n_dbl, n_long, n_rep, first_cyc, cyc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clr();
        n_short = 0; n_dbl = 0; n_long = 0; n_rep = 0;
        first_cyc = -1; cyc = 0;
    endtask

    // Drive one cycle, sample just after the edge, and run the pulse-shape monitor.
    task automatic step(input logic k);
        key_state = k;
        @(posedge clk);
        #1;
        outs = {short_press, double_click, long_press, auto_repeat};
        if ($countones(outs) > 1) mon_viol++;
        if ((outs & prev_out) != 4'b0) mon_viol++;
        prev_out = outs;
        if (short_press)  n_short++;
        if (double_click) n_dbl++;
        if (long_press)   n_long++;
        if (auto_repeat)  n_rep++;
        if (outs != 4'b0 && first_cyc < 0) first_cyc = cyc;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        //          h1  l1  h2 tail  sh db lg rp first
        vecs[0]  = '{0, 20,  0,  0,  0, 0, 0, 0, -1};
        vecs[1]  = '{5, 15,  0,  0,  1, 0, 0, 0, 15};
        vecs[2]  = '{5,  4,  5, 10,  0, 1, 0, 0, 14};
        vecs[3]  = '{40, 10, 0,  0,  0, 0, 1, 3, 20};
        vecs[4]  = '{20, 15, 0,  0,  1, 0, 0, 0, 30};
        vecs[5]  = '{21, 15, 0,  0,  0, 0, 1, 0, 20};
        vecs[6]  = '{5,  9,  3,  5,  0, 1, 0, 0, 17};
        vecs[7]  = '{5, 10,  3,  5,  0, 1, 0, 0, 18};
        vecs[8]  = '{5, 11,  3, 15,  2, 0, 0, 0, 15};
        vecs[9]  = '{3,  2, 30,  3,  0, 1, 0, 0, 35};
        vecs[10] = '{26, 5,  0,  0,  0, 0, 1, 1, 20};
        vecs[11] = '{25, 5,  0,  0,  0, 0, 1, 0, 20};

        reset = 1'b1;
        key_state = 1'b0;
        do_reset();
        check("reset_outs", int'(outs), 0);

        for (int v = 0; v < 12; v++) begin
            do_reset();
            clr();
            for (int i = 0; i < vecs[v].h1; i++)   step(1'b1);
            for (int i = 0; i < vecs[v].l1; i++)   step(1'b0);
            for (int i = 0; i < vecs[v].h2; i++)   step(1'b1);
            for (int i = 0; i < vecs[v].tail; i++) step(1'b0);
            check($sformatf("v%0d_short", v), n_short, vecs[v].exp_short);
            check($sformatf("v%0d_double", v), n_dbl, vecs[v].exp_dbl);
            check($sformatf("v%0d_long", v), n_long, vecs[v].exp_long);
            check($sformatf("v%0d_repeat", v), n_rep, vecs[v].exp_rep);
            check($sformatf("v%0d_first_cyc", v), first_cyc, vecs[v].exp_first);
        end

        // Reset lands on the edge that would have fired long_press.
        do_reset();
        clr();
        for (int i = 0; i < 20; i++) step(1'b1);
        check("pre_reset_no_pulse", n_short + n_dbl + n_long + n_rep, 0);
        reset = 1'b1;
        step(1'b1);
        check("reset_kills_pending", int'(outs), 0);
        step(1'b1);
        check("reset_held_outs", int'(outs), 0);
        reset = 1'b0;
        // Key still high at release: a fresh press, long_press 20 edges later.
        clr();
        for (int i = 0; i < 21; i++) step(1'b1);
        check("restart_long", n_long, 1);
        check("restart_long_cyc", first_cyc, 20);
        for (int i = 0; i < 15; i++) step(1'b0);
        check("restart_no_other", n_short + n_dbl + n_rep, 0);

        // Reset mid-PRESS1 early in the hold, then release with key low: nothing at all.
        do_reset();
        clr();
        for (int i = 0; i < 5; i++) step(1'b1);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) step(1'b0);
        check("mid_press_reset_silent", n_short + n_dbl + n_long + n_rep, 0);

        check("monitor_violations", mon_viol, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
